// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: retires MEM-stage payloads into the register file and CP0,
// and sequences TLBP/TLBR/TLBWI through a two-cycle access/commit FSM.
module wb_commit_stage #(
  parameter int TLBNUM = 16,
  parameter int CNT_W  = 32,
  localparam int IDX_W = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ms_to_ws_valid,
  output logic               ws_allowin,
  input  logic [31:0]        ms_pc,
  input  logic [31:0]        ms_result,
  input  logic [31:0]        ms_badvaddr,
  input  logic [4:0]         ms_dest,
  input  logic               ms_gr_we,
  input  logic               ms_cp0_op,
  input  logic               ms_cp0_we,
  input  logic               ms_bd,
  input  logic               ms_eret,
  input  logic [7:0]         ms_cp0_addr,
  input  logic               ms_ex,
  input  logic [4:0]         ms_excode,
  input  logic [1:0]         ms_tlbop,
  input  logic               ms_s1_found,
  input  logic [IDX_W-1:0]   ms_s1_index,
  input  logic [31:0]        c0_rdata,
  input  logic [31:0]        cp0_index,
  input  logic [31:0]        cp0_entryhi,
  input  logic [31:0]        cp0_entrylo0,
  input  logic [31:0]        cp0_entrylo1,
  input  logic [18:0]        r_vpn2,
  input  logic [7:0]         r_asid,
  input  logic               r_g,
  input  logic [19:0]        r_pfn0,
  input  logic [19:0]        r_pfn1,
  input  logic [2:0]         r_c0,
  input  logic [2:0]         r_c1,
  input  logic               r_d0,
  input  logic               r_d1,
  input  logic               r_v0,
  input  logic               r_v1,
  output logic [IDX_W-1:0]   r_index,
  output logic               tlb_we,
  output logic [IDX_W-1:0]   w_index,
  output logic [18:0]        w_vpn2,
  output logic [7:0]         w_asid,
  output logic               w_g,
  output logic [19:0]        w_pfn0,
  output logic [19:0]        w_pfn1,
  output logic [2:0]         w_c0,
  output logic [2:0]         w_c1,
  output logic               w_d0,
  output logic               w_d1,
  output logic               w_v0,
  output logic               w_v1,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               c0_we,
  output logic [7:0]         c0_addr,
  output logic [31:0]        c0_wdata,
  output logic               tlbr_we,
  output logic [77:0]        tlbr_data,
  output logic               tlbp_we,
  output logic               tlbp_p,
  output logic [IDX_W-1:0]   tlbp_index,
  output logic               wb_ex,
  output logic [4:0]         wb_excode,
  output logic               wb_bd,
  output logic [31:0]        wb_pc,
  output logic [31:0]        wb_badvaddr,
  output logic               wb_eret,
  output logic               cancel,
  output logic [31:0]        cancel_pc,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [31:0]        debug_wb_pc,
  output logic [3:0]         debug_wb_rf_wen,
  output logic [4:0]         debug_wb_rf_wnum,
  output logic [31:0]        debug_wb_rf_wdata
);

  localparam logic [1:0] OP_TLBP  = 2'b01;
  localparam logic [1:0] OP_TLBR  = 2'b10;
  localparam logic [1:0] OP_TLBWI = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_CMT = 2'd2} state_t;

  state_t             state_r, state_nxt_s;
  logic               ws_valid_r;
  logic [31:0]        ws_pc_r, ws_result_r, ws_badvaddr_r;
  logic [4:0]         ws_dest_r, ws_excode_r;
  logic               ws_gr_we_r, ws_cp0_op_r, ws_cp0_we_r, ws_bd_r, ws_eret_r, ws_ex_r;
  logic [7:0]         ws_cp0_addr_r;
  logic [1:0]         ws_tlbop_r;
  logic               ws_s1_found_r;
  logic [IDX_W-1:0]   ws_s1_index_r;
  logic [77:0]        tlbr_data_r;
  logic               tlbp_found_r;
  logic [IDX_W-1:0]   tlbp_index_r;
  logic [CNT_W-1:0]   retire_cnt_r;
  logic               tlb_act_s, ws_ready_go_s, retire_s, flush_s;
  logic               unused_ok_s;

  // A TLB op only occupies the sequencer when it is valid and not already excepting.
  assign tlb_act_s     = ws_valid_r && !ws_ex_r && (ws_tlbop_r != 2'b00);
  assign ws_ready_go_s = tlb_act_s ? (state_r == S_CMT) : 1'b1;
  assign ws_allowin    = !ws_valid_r || ws_ready_go_s;
  assign retire_s      = ws_valid_r && ws_ready_go_s;
  assign flush_s       = wb_ex || wb_eret || cancel;

  // Stage valid bit: cleared on any flush the stage itself raises.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_r <= 1'b0;
    end else if (flush_s) begin
      ws_valid_r <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid_r <= ms_to_ws_valid;
    end
  end

  // Payload register, loaded on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_pc_r       <= 32'd0;
      ws_result_r   <= 32'd0;
      ws_badvaddr_r <= 32'd0;
      ws_dest_r     <= 5'd0;
      ws_gr_we_r    <= 1'b0;
      ws_cp0_op_r   <= 1'b0;
      ws_cp0_we_r   <= 1'b0;
      ws_bd_r       <= 1'b0;
      ws_eret_r     <= 1'b0;
      ws_cp0_addr_r <= 8'd0;
      ws_ex_r       <= 1'b0;
      ws_excode_r   <= 5'd0;
      ws_tlbop_r    <= 2'b00;
      ws_s1_found_r <= 1'b0;
      ws_s1_index_r <= '0;
    end else if (ms_to_ws_valid && ws_allowin) begin
      ws_pc_r       <= ms_pc;
      ws_result_r   <= ms_result;
      ws_badvaddr_r <= ms_badvaddr;
      ws_dest_r     <= ms_dest;
      ws_gr_we_r    <= ms_gr_we;
      ws_cp0_op_r   <= ms_cp0_op;
      ws_cp0_we_r   <= ms_cp0_we;
      ws_bd_r       <= ms_bd;
      ws_eret_r     <= ms_eret;
      ws_cp0_addr_r <= ms_cp0_addr;
      ws_ex_r       <= ms_ex;
      ws_excode_r   <= ms_excode;
      ws_tlbop_r    <= ms_tlbop;
      ws_s1_found_r <= ms_s1_found;
      ws_s1_index_r <= ms_s1_index;
    end
  end

  // TLB sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // TLB sequencer next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (tlb_act_s) begin
          state_nxt_s = S_ACC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ACC:   state_nxt_s = S_CMT;
      S_CMT:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // TLB sequencer strobes.
  always_comb begin
    tlb_we  = 1'b0;
    tlbr_we = 1'b0;
    tlbp_we = 1'b0;
    cancel  = 1'b0;
    if (tlb_act_s && (state_r == S_ACC)) begin
      tlb_we = (ws_tlbop_r == OP_TLBWI);
    end else if (tlb_act_s && (state_r == S_CMT)) begin
      tlbr_we = (ws_tlbop_r == OP_TLBR);
      tlbp_we = (ws_tlbop_r == OP_TLBP);
      cancel  = (ws_tlbop_r == OP_TLBR) || (ws_tlbop_r == OP_TLBWI);
    end else begin
      tlb_we  = 1'b0;
      tlbr_we = 1'b0;
      tlbp_we = 1'b0;
      cancel  = 1'b0;
    end
  end

  // Latch TLB read data / probe result during the access cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tlbr_data_r  <= 78'd0;
      tlbp_found_r <= 1'b0;
      tlbp_index_r <= '0;
    end else if (tlb_act_s && (state_r == S_ACC)) begin
      case (ws_tlbop_r)
        OP_TLBR: tlbr_data_r <= {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                                 r_pfn1, r_c1, r_d1, r_v1};
        OP_TLBP: begin
          tlbp_found_r <= ws_s1_found_r;
          tlbp_index_r <= ws_s1_index_r;
        end
        default: tlbr_data_r <= tlbr_data_r;
      endcase
    end
  end

  // Retired-instruction counter; excepting instructions do not count.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_r <= '0;
    end else if (retire_s && !ws_ex_r) begin
      retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rf_we       = retire_s && ws_gr_we_r && !ws_ex_r;
  assign rf_waddr    = ws_dest_r;
  assign rf_wdata    = ws_cp0_op_r ? c0_rdata : ws_result_r;
  assign c0_we       = retire_s && ws_cp0_we_r && !ws_ex_r;
  assign c0_addr     = ws_cp0_addr_r;
  assign c0_wdata    = ws_result_r;
  assign wb_ex       = ws_valid_r && ws_ex_r;
  assign wb_eret     = ws_valid_r && ws_eret_r && !ws_ex_r;
  assign wb_excode   = ws_excode_r;
  assign wb_bd       = ws_bd_r;
  assign wb_pc       = ws_pc_r;
  assign wb_badvaddr = ws_badvaddr_r;
  assign cancel_pc   = ws_pc_r + 32'd4;
  assign retire_cnt  = retire_cnt_r;
  assign tlbr_data   = tlbr_data_r;
  assign tlbp_p      = !tlbp_found_r;
  assign tlbp_index  = tlbp_index_r;

  // TLB write image comes straight from the live CP0 Index/EntryHi/EntryLo values.
  assign r_index = cp0_index[IDX_W-1:0];
  assign w_index = cp0_index[IDX_W-1:0];
  assign w_vpn2  = cp0_entryhi[31:13];
  assign w_asid  = cp0_entryhi[7:0];
  assign w_g     = cp0_entrylo0[0] & cp0_entrylo1[0];
  assign w_pfn0  = cp0_entrylo0[25:6];
  assign w_c0    = cp0_entrylo0[5:3];
  assign w_d0    = cp0_entrylo0[2];
  assign w_v0    = cp0_entrylo0[1];
  assign w_pfn1  = cp0_entrylo1[25:6];
  assign w_c1    = cp0_entrylo1[5:3];
  assign w_d1    = cp0_entrylo1[2];
  assign w_v1    = cp0_entrylo1[1];

  assign debug_wb_pc       = ws_pc_r;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = ws_dest_r;
  assign debug_wb_rf_wdata = rf_wdata;

  assign unused_ok_s = ^{cp0_index[31:IDX_W], cp0_entryhi[12:8],
                         cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

endmodule
